rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between in-order pipeline writeback (WB) and the multi-cycle MDU.
//  Pipeline WB has priority; MDU results queue in a small FIFO and drain on idle WB cycles.
//  A starvation guard stalls the pipeline to force a drain, and an optional scoreboard tracks pending MDU destinations.
//  Sits between the WB stage / MDU and the register file write port (we/addr/data).
// PARAMETERS
//  ADDR_W      5   register address width
//  DATA_W      32  register data width
//  FIFO_DEPTH  2   MDU result queue entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive non-drained cycles before forced drain
// PORTS
//  clk_i         in   1       clock
//  rst_i         in   1       reset
//  wb_we_i       in   1       pipeline WB write valid
//  wb_addr_i     in   ADDR_W  pipeline WB destination
//  wb_data_i     in   DATA_W  pipeline WB data
//  mdu_valid_i   in   1       MDU result valid
//  mdu_ready_o   out  1       FIFO can accept MDU result
//  mdu_addr_i    in   ADDR_W  MDU destination
//  mdu_data_i    in   DATA_W  MDU result
//  issue_i       in   1       MDU op issued this cycle (scoreboard set)
//  issue_addr_i  in   ADDR_W  destination of issued MDU op
//  stall_o       out  1       pipeline must hold WB this cycle
//  busy_o        out  2**ADDR_W  per-register pending-MDU-write flags
//  rf_we_o       out  1       register file write enable
//  rf_addr_o     out  ADDR_W  register file write address
//  rf_data_o     out  DATA_W  register file write data
// BEHAVIOUR
//  - Reset rst_i, asynchronous, active-high; clock clk_i.
//  - Reset state: FIFO empty, starvation counter 0, busy_o=0, stall_o=0, rf_we_o=0, mdu_ready_o=0 while rst_i=1.
//  - Reset mid-operation discards all queued results.
//  - MDU accept: push on mdu_valid_i & mdu_ready_o at a posedge.
//    - mdu_ready_o = !full (registered occupancy). A push into a full FIFO cannot occur.
//    - Simultaneous push+pop when full is not accepted (ready is already 0).
//  - Port select is combinational from current inputs and registered state:
//    - stall_o=0 & wb_we_i=1: drive WB; FIFO holds.
//    - Otherwise, FIFO non-empty: drive the head and pop at the posedge.
//    - Otherwise: rf_we_o=0.
//    - When stall_o=1, wb_we_i is ignored; the pipeline re-presents it next cycle.
//  - Latency: an MDU result accepted at edge N is written at edge N+1 at the earliest.
//  - Address 0: a selected write to addr 0 yields rf_we_o=0 but is still consumed/popped.
//  - Squash (WAW): when WB writes addr A, every FIFO entry with addr A is marked dead.
//    - Dead entries still pop, with rf_we_o=0. WB is younger and wins.
//  - Starvation counter:
//    - Increments each cycle the FIFO is non-empty and no pop occurs; clears on pop or when empty.
//    - stall_o is registered: it asserts the cycle after the counter reaches STARVE_MAX, lasts exactly 1 cycle, and clears the counter.
//  - FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is ADDR-independent, width clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  RF_WB_SCOREBOARD_EN defined:
//    - issue_i with issue_addr_i!=0 sets busy_o[issue_addr_i].
//    - A pop (live or dead) of addr A clears busy_o[A].
//    - Same-cycle set and clear on the same address: set wins.
//  RF_WB_SCOREBOARD_EN undefined: busy_o tied 0; issue_i/issue_addr_i ignored; no scoreboard flops.
// STRUCTURE
//  Shared package rf_pkg:
//    - RF_ADDR_W=5, RF_DATA_W=32, RF_NREGS=32.
//    - typedef rf_wr_t {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}.
//  Sub-module rf_wb_fifo: depth-parameterised queue with per-entry live bit, push/pop, and squash-by-address input.
//  Arbitration, starvation counter and scoreboard stay in rf_wb_arbiter.
// TESTING
//  1 Reset, then WB writes r3=0x11 each cycle; no MDU -> rf_we_o=1, rf_addr_o=3, rf_data_o=0x11 every cycle; stall_o=0.
//  2 WB idle; MDU pushes r5=0xABCD -> rf_we_o=1, addr 5, data 0xABCD on the next cycle; FIFO empties.
//  3 WB busy every cycle; MDU pushes r7, r8 -> mdu_ready_o=0 after 2 pushes.
//    Expect stall_o=1 in cycle STARVE_MAX+1; r7 written then; r8 drains on the next forced stall.
//  4 FIFO holds r9=0x1; WB writes r9=0x2 -> entry squashed; later pop gives rf_we_o=0; r9 final value 0x2.
//  5 MDU pushes r0=0xFF with WB idle -> pop occurs, rf_we_o=0.
//    Assert rst_i mid-queue -> mdu_ready_o=0 and FIFO empty after release.
//  6 (RF_WB_SCOREBOARD_EN) issue r4 -> busy_o[4]=1; its pop clears it.
//    Issue r4 in the same cycle as a pop of r4 -> busy_o[4] stays 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths and the write-port record
// used by everything that talks to the register file write port.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;

  // One register file write: enable, destination, payload.
  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between WB stage / MDU / scoreboard users and the write-port
// arbiter. The arbiter connects through the slave modport; the pipeline side
// (or a testbench) uses master.
//
// Handshake: an MDU result transfers at a rising clk_i edge when
// mdu_valid_i && mdu_ready_o are both high. mdu_valid_i may be raised
// regardless of mdu_ready_o; the payload must be held stable until the
// transfer edge. WB writes have no handshake: while stall_o is high the
// write is ignored and must be presented again on the next cycle.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  logic                   wb_we_i;
  logic [ADDR_W-1:0]      wb_addr_i;
  logic [DATA_W-1:0]      wb_data_i;
  logic                   mdu_valid_i;
  logic                   mdu_ready_o;
  logic [ADDR_W-1:0]      mdu_addr_i;
  logic [DATA_W-1:0]      mdu_data_i;
  logic                   issue_i;
  logic [ADDR_W-1:0]      issue_addr_i;
  logic                   stall_o;
  logic [2**ADDR_W-1:0]   busy_o;
  logic                   rf_we_o;
  logic [ADDR_W-1:0]      rf_addr_o;
  logic [DATA_W-1:0]      rf_data_o;

  modport slave (
    input  wb_we_i, wb_addr_i, wb_data_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i,
    input  issue_i, issue_addr_i,
    output mdu_ready_o, stall_o, busy_o,
    output rf_we_o, rf_addr_o, rf_data_o
  );

  modport master (
    output wb_we_i, wb_addr_i, wb_data_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i,
    output issue_i, issue_addr_i,
    input  mdu_ready_o, stall_o, busy_o,
    input  rf_we_o, rf_addr_o, rf_data_o
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small in-order queue of MDU results. Each entry carries a live bit so a
// younger WB write to the same register can kill it without reordering;
// killed entries still drain through the head like any other.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [ADDR_W-1:0] squash_addr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_live_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              live_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign full_o      = (count == CNT_W'(DEPTH));
  assign empty_o     = (count == '0);
  assign head_addr_o = addr_mem[rd_ptr];
  assign head_data_o = data_mem[rd_ptr];
  assign head_live_o = live_mem[rd_ptr];

  // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_i)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: squash kills matching entries; a same-edge push lands live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_i && (addr_mem[i] == squash_addr_i)) live_mem[i] <= 1'b0;
    end
    if (push_i) begin
      addr_mem[wr_ptr] <= push_addr_i;
      data_mem[wr_ptr] <= push_data_i;
      live_mem[wr_ptr] <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, MDU results
// queue and drain on idle WB cycles, and a starvation guard stalls WB for one
// cycle to force a drain. Optional pending-write scoreboard is built only
// when RF_WB_SCOREBOARD_EN is defined; otherwise busy_o is tied to zero.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  rf_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic              fifo_full, fifo_empty, head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push, pop, wb_sel, squash;
  logic              stall_q;
  logic [CNT_W-1:0]  starve_cnt, starve_next;

  assign bus.mdu_ready_o = !fifo_full && !rst_i;
  assign push   = bus.mdu_valid_i && bus.mdu_ready_o;
  assign wb_sel = !stall_q && bus.wb_we_i;
  assign pop    = !fifo_empty && !wb_sel;
  assign squash = wb_sel && (bus.wb_addr_i != '0);
  assign bus.stall_o = stall_q;

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_addr_i  (bus.mdu_addr_i),
    .push_data_i  (bus.mdu_data_i),
    .pop_i        (pop),
    .squash_i     (squash),
    .squash_addr_i(bus.wb_addr_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_live_o  (head_live)
  );

  // Write-port mux: WB wins unless stalled, else the FIFO head; r0 never writes.
  always_comb begin
    bus.rf_we_o   = 1'b0;
    bus.rf_addr_o = head_addr;
    bus.rf_data_o = head_data;
    if (rst_i) begin
      bus.rf_we_o = 1'b0;
    end else if (wb_sel) begin
      bus.rf_we_o   = (bus.wb_addr_i != '0);
      bus.rf_addr_o = bus.wb_addr_i;
      bus.rf_data_o = bus.wb_data_i;
    end else if (pop) begin
      bus.rf_we_o = head_live && (head_addr != '0);
    end
  end

  // Starvation count: consecutive cycles with queued data that did not drain.
  always_comb begin
    starve_next = '0;
    if (!stall_q && !pop && !fifo_empty) starve_next = starve_cnt + CNT_W'(1);
  end

  // Stall fires for one cycle right after the count reaches its limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_q    <= (starve_next == CNT_W'(STARVE_MAX));
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] busy_q, busy_set, busy_clr;

  // Issue marks a destination pending; its pop (live or dead) retires it.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (bus.issue_i && (bus.issue_addr_i != '0)) busy_set[bus.issue_addr_i] = 1'b1;
    if (pop) busy_clr[head_addr] = 1'b1;
  end

  // Set is applied after clear so a same-cycle re-issue keeps the flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= (busy_q & ~busy_clr) | busy_set;
  end

  assign bus.busy_o = busy_q;
`else
  logic unused_sb;
  assign unused_sb  = ^{bus.issue_i, bus.issue_addr_i};
  assign bus.busy_o = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a queue-based
// model of the arbitration rules. Scoreboard scenario builds with
// RF_WB_SCOREBOARD_EN.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  rf_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  rf_wb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.wb_we_i      = 1'b0;
    bus.wb_addr_i    = '0;
    bus.wb_data_i    = '0;
    bus.mdu_valid_i  = 1'b0;
    bus.mdu_addr_i   = '0;
    bus.mdu_data_i   = '0;
    bus.issue_i      = 1'b0;
    bus.issue_addr_i = '0;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_we_i   = 1'b1;
    bus.wb_addr_i = a;
    bus.wb_data_i = d;
  endtask

  task automatic mdu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.mdu_valid_i = 1'b1;
    bus.mdu_addr_i  = a;
    bus.mdu_data_i  = d;
  endtask

  // ---------------- scoreboard / model ----------------
  // Pending MDU results in arrival order; .we doubles as the "still live" flag.
  rf_wr_t            exp_q[$];
  bit                m_stall;
  int                m_starve;
  logic [31:0]       m_busy;
  logic [DATA_W-1:0] rf_img [RF_NREGS];

  int                c_n;
  bit                c_wbsel, c_pop, c_we, c_nstall;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [31:0]       c_set, c_clr;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      m_stall  = 1'b0;
      m_starve = 0;
      m_busy   = '0;
      check("rst_ready", bus.mdu_ready_o, 0);
      check("rst_stall", bus.stall_o, 0);
      check("rst_rf_we", bus.rf_we_o, 0);
      check("rst_busy",  bus.busy_o, 0);
    end else begin
      c_n     = exp_q.size();
      c_wbsel = !m_stall && bus.wb_we_i;
      c_pop   = (c_n > 0) && !c_wbsel;
      c_addr  = '0;
      c_data  = '0;
      c_we    = 1'b0;
      if (c_wbsel) begin
        c_we   = (bus.wb_addr_i != 0);
        c_addr = bus.wb_addr_i;
        c_data = bus.wb_data_i;
      end else if (c_pop) begin
        c_we   = exp_q[0].we && (exp_q[0].addr != 0);
        c_addr = exp_q[0].addr;
        c_data = exp_q[0].data;
      end
      check("stall", bus.stall_o, m_stall);
      check("ready", bus.mdu_ready_o, (c_n < FIFO_DEPTH));
      check("rf_we", bus.rf_we_o, c_we);
      if (c_we) begin
        check("rf_addr", bus.rf_addr_o, c_addr);
        check("rf_data", bus.rf_data_o, c_data);
      end
      check("busy", bus.busy_o, m_busy);
      if (bus.rf_we_o) rf_img[bus.rf_addr_o] = bus.rf_data_o;

      // advance model to the state after the coming edge
      c_set = '0;
      c_clr = '0;
`ifdef RF_WB_SCOREBOARD_EN
      if (bus.issue_i && bus.issue_addr_i != 0) c_set[bus.issue_addr_i] = 1'b1;
      if (c_pop) c_clr[exp_q[0].addr] = 1'b1;
`endif
      m_busy = (m_busy & ~c_clr) | c_set;
      if (c_wbsel && bus.wb_addr_i != 0) begin
        foreach (exp_q[i]) if (exp_q[i].addr == bus.wb_addr_i) exp_q[i].we = 1'b0;
      end
      if (c_pop) void'(exp_q.pop_front());
      if (bus.mdu_valid_i && (c_n < FIFO_DEPTH))
        exp_q.push_back(rf_wr_t'{we: 1'b1, addr: bus.mdu_addr_i, data: bus.mdu_data_i});
      c_nstall = 1'b0;
      if (m_stall || c_n == 0 || c_pop) begin
        m_starve = 0;
      end else begin
        m_starve++;
        if (m_starve == STARVE_MAX) c_nstall = 1'b1;
      end
      m_stall = c_nstall;
    end
  end

  // ---------------- stimulus ----------------
  int first_stall, second_stall;
  int wb_pct;

  initial begin
    idle();
    repeat (3) cyc();
    @(negedge clk_i);
    check("t0_ready_in_reset", bus.mdu_ready_o, 0);
    cyc();
    rst_i = 1'b0;

    // 1: WB every cycle, no MDU
    wb(3, 32'h11);
    repeat (5) begin
      @(negedge clk_i);
      check("t1_we",    bus.rf_we_o, 1);
      check("t1_addr",  bus.rf_addr_o, 3);
      check("t1_data",  bus.rf_data_o, 32'h11);
      check("t1_stall", bus.stall_o, 0);
      cyc();
    end
    idle();

    // 2: MDU result drains on the next idle cycle
    mdu(5, 32'hABCD);
    @(negedge clk_i);
    check("t2_ready", bus.mdu_ready_o, 1);
    cyc();
    idle();
    @(negedge clk_i);
    check("t2_we",   bus.rf_we_o, 1);
    check("t2_addr", bus.rf_addr_o, 5);
    check("t2_data", bus.rf_data_o, 32'hABCD);
    cyc();
    @(negedge clk_i);
    check("t2_empty_we", bus.rf_we_o, 0);
    cyc();

    // 3: WB saturates the port; starvation guard forces drains
    wb(1, 32'h100);
    mdu(7, 32'h77);
    @(negedge clk_i);
    cyc();
    mdu(8, 32'h88);
    @(negedge clk_i);
    cyc();
    bus.mdu_valid_i = 1'b0;
    first_stall  = -1;
    second_stall = -1;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk_i);
      if (k == 2) check("t3_ready_full", bus.mdu_ready_o, 0);
      if (bus.stall_o) begin
        if (first_stall < 0) begin
          first_stall = k;
          check("t3_r7_we",   bus.rf_we_o, 1);
          check("t3_r7_addr", bus.rf_addr_o, 7);
        end else if (second_stall < 0) begin
          second_stall = k;
          check("t3_r8_addr", bus.rf_addr_o, 8);
          check("t3_r8_data", bus.rf_data_o, 32'h88);
        end
      end
      cyc();
    end
    check("t3_first_stall_cycle",  first_stall,  STARVE_MAX + 1);
    check("t3_second_stall_cycle", second_stall, 2 * STARVE_MAX + 2);
    idle();

    // 4: younger WB write squashes the queued MDU result
    wb(2, 32'h5);
    mdu(9, 32'h1);
    @(negedge clk_i);
    cyc();
    bus.mdu_valid_i = 1'b0;
    wb(9, 32'h2);
    @(negedge clk_i);
    check("t4_wb_addr", bus.rf_addr_o, 9);
    cyc();
    idle();
    @(negedge clk_i);
    check("t4_dead_pop_we", bus.rf_we_o, 0);
    cyc();
    @(negedge clk_i);
    check("t4_r9_final", rf_img[9], 32'h2);
    check("t4_ready", bus.mdu_ready_o, 1);
    cyc();

    // 5: r0 result is popped but never written; reset drops queued results
    mdu(0, 32'hFF);
    @(negedge clk_i);
    cyc();
    idle();
    @(negedge clk_i);
    check("t5_r0_we", bus.rf_we_o, 0);
    cyc();
    wb(1, 32'h3);
    mdu(10, 32'hA);
    @(negedge clk_i);
    cyc();
    mdu(11, 32'hB);
    @(negedge clk_i);
    cyc();
    bus.mdu_valid_i = 1'b0;
    @(negedge clk_i);
    check("t5_full_ready", bus.mdu_ready_o, 0);
    #2 rst_i = 1'b1;
    #1 check("t5_ready_in_reset", bus.mdu_ready_o, 0);
    cyc();
    cyc();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    check("t5_ready_after", bus.mdu_ready_o, 1);
    check("t5_we_after",    bus.rf_we_o, 0);
    cyc();
    @(negedge clk_i);
    check("t5_no_drain", bus.rf_we_o, 0);
    cyc();

`ifdef RF_WB_SCOREBOARD_EN
    // 6: scoreboard set / clear / set-wins
    bus.issue_i = 1'b1; bus.issue_addr_i = 4;
    cyc();
    bus.issue_i = 1'b0;
    mdu(4, 32'h44);
    @(negedge clk_i);
    check("t6_busy_set", bus.busy_o[4], 1);
    cyc();
    bus.mdu_valid_i = 1'b0;
    @(negedge clk_i);
    check("t6_busy_before_pop", bus.busy_o[4], 1);
    cyc();
    @(negedge clk_i);
    check("t6_busy_cleared", bus.busy_o[4], 0);
    bus.issue_i = 1'b1; bus.issue_addr_i = 4;
    cyc();
    bus.issue_i = 1'b0;
    mdu(4, 32'h45);
    cyc();
    bus.mdu_valid_i = 1'b0;
    bus.issue_i = 1'b1; bus.issue_addr_i = 4;
    cyc();
    bus.issue_i = 1'b0;
    @(negedge clk_i);
    check("t6_set_wins", bus.busy_o[4], 1);
    cyc();
`else
    bus.issue_i = 1'b1; bus.issue_addr_i = 4;
    cyc();
    bus.issue_i = 1'b0;
    @(negedge clk_i);
    check("t6_busy_tied0", bus.busy_o, 0);
    cyc();
`endif

    // random traffic at several WB loads, with one reset mid-stream
    for (int p = 0; p < 3; p++) begin
      wb_pct = (p == 0) ? 30 : (p == 1) ? 85 : 100;
      for (int i = 0; i < 600; i++) begin
        if (p == 1 && i == 300) begin
          rst_i = 1'b1;
          cyc();
          cyc();
          rst_i = 1'b0;
        end
        bus.wb_we_i      = ($urandom_range(0, 99) < wb_pct);
        bus.wb_addr_i    = ADDR_W'($urandom_range(0, 7));
        bus.wb_data_i    = $urandom;
        bus.mdu_valid_i  = ($urandom_range(0, 1) == 1);
        bus.mdu_addr_i   = ADDR_W'($urandom_range(0, 7));
        bus.mdu_data_i   = $urandom;
        bus.issue_i      = ($urandom_range(0, 3) == 0);
        bus.issue_addr_i = ADDR_W'($urandom_range(0, 7));
        cyc();
      end
    end
    idle();
    repeat (3 * STARVE_MAX) cyc();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
